alu_operand_stage: RTL

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_pkg.sv | 41 ++++
 rtl/alu_operand_stage_funct.sv | 31 +++
 rtl/alu_operand_stage.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ALU and its operand stage: ALU opcodes,
// R-type function codes and the skid-buffer state encoding.
package alu_operand_stage_pkg;

  localparam logic [3:0] ALU_ADD      = 4'h0;
  localparam logic [3:0] ALU_SUB      = 4'h1;
  localparam logic [3:0] ALU_AND      = 4'h3;
  localparam logic [3:0] ALU_OR       = 4'h4;
  localparam logic [3:0] ALU_XOR      = 4'h5;
  localparam logic [3:0] ALU_NOR      = 4'h6;
  localparam logic [3:0] ALU_SLTU     = 4'h7;
  localparam logic [3:0] ALU_SLT      = 4'h8;
  localparam logic [3:0] ALU_SLL      = 4'h9;
  localparam logic [3:0] ALU_SRL      = 4'hA;
  localparam logic [3:0] ALU_SRA      = 4'hB;
  localparam logic [3:0] ALU_ACCU_SUM = 4'hC;
  localparam logic [3:0] ALU_INVALID  = 4'hF;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  // state    | meaning
  // ST_EMPTY | no entry held, out_valid low
  // ST_ONE   | head entry valid, second slot free
  // ST_FULL  | both slots occupied, in_ready low
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/alu_operand_stage_funct.sv
// Combinational R-type funct to ALU opcode map, with a flag marking the
// immediate-shift functions whose first operand is the shift amount.
module alu_funct_decode
  import alu_operand_stage_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       shift_sel
);

  // Table lookup; anything unrecognised maps to the invalid opcode.
  always_comb begin
    alu_op    = ALU_INVALID;
    shift_sel = 1'b0;
    case (funct)
      FUNCT_ADD:  alu_op = ALU_ADD;
      FUNCT_SUB:  alu_op = ALU_SUB;
      FUNCT_AND:  alu_op = ALU_AND;
      FUNCT_OR:   alu_op = ALU_OR;
      FUNCT_XOR:  alu_op = ALU_XOR;
      FUNCT_NOR:  alu_op = ALU_NOR;
      FUNCT_SLTU: alu_op = ALU_SLTU;
      FUNCT_SLT:  alu_op = ALU_SLT;
      FUNCT_SLL:  begin alu_op = ALU_SLL; shift_sel = 1'b1; end
      FUNCT_SRL:  begin alu_op = ALU_SRL; shift_sel = 1'b1; end
      FUNCT_SRA:  begin alu_op = ALU_SRA; shift_sel = 1'b1; end
      default:    alu_op = ALU_INVALID;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand stage between decode and the ALU: a two-entry skid buffer that
// captures register operands, keeps them fresh from the writeback bypass
// while they wait, and presents the decoded ALU command from the head entry.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            in_funct,
  input  logic [4:0]            in_shamt,
  input  logic [REG_AW-1:0]     in_rs_addr,
  input  logic [REG_AW-1:0]     in_rt_addr,
  input  logic [REG_AW-1:0]     in_rd_addr,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  input  logic                  fwd_valid,
  input  logic [REG_AW-1:0]     fwd_addr,
  input  logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            ALUOp,
  output logic                  sel,
  output logic [DATA_WIDTH-1:0] in1,
  output logic [DATA_WIDTH-1:0] in2,
  output logic [DATA_WIDTH-1:0] in3,
  output logic [DATA_WIDTH-1:0] in4,
  output logic [REG_AW-1:0]     dst_addr
);

  skid_state_t state;

  logic [5:0]            funct_q   [2];
  logic [4:0]            shamt_q   [2];
  logic [REG_AW-1:0]     rs_addr_q [2];
  logic [REG_AW-1:0]     rt_addr_q [2];
  logic [REG_AW-1:0]     rd_addr_q [2];
  logic [DATA_WIDTH-1:0] rs_data_q [2];
  logic [DATA_WIDTH-1:0] rt_data_q [2];

  logic       accept;
  logic       issue;
  logic       wr_slot;
  logic       shift_head;
  logic [3:0] head_op;
  logic       head_shift;

  assign accept     = in_valid && in_ready;
  assign issue      = out_valid && out_ready;
  // Slot 1 is only written when the head stays put this cycle.
  assign wr_slot    = (state == ST_ONE) && !issue;
  assign shift_head = (state == ST_FULL) && issue;

  // Register 0 reads as zero; otherwise a matching writeback wins.
  function automatic logic [DATA_WIDTH-1:0] fwd_pick(
    input logic [REG_AW-1:0]     addr,
    input logic [DATA_WIDTH-1:0] dflt
  );
    if (addr == '0)
      fwd_pick = '0;
    else if (fwd_valid && (fwd_addr == addr))
      fwd_pick = fwd_data;
    else
      fwd_pick = dflt;
  endfunction

  // Occupancy FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !issue) begin
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (issue && !accept) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (issue) begin
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Entry storage: bypass refresh, then head advance, then capture (last write wins).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        funct_q[i]   <= '0;
        shamt_q[i]   <= '0;
        rs_addr_q[i] <= '0;
        rt_addr_q[i] <= '0;
        rd_addr_q[i] <= '0;
        rs_data_q[i] <= '0;
        rt_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        rs_data_q[i] <= fwd_pick(rs_addr_q[i], rs_data_q[i]);
        rt_data_q[i] <= fwd_pick(rt_addr_q[i], rt_data_q[i]);
      end
      if (shift_head) begin
        funct_q[0]   <= funct_q[1];
        shamt_q[0]   <= shamt_q[1];
        rs_addr_q[0] <= rs_addr_q[1];
        rt_addr_q[0] <= rt_addr_q[1];
        rd_addr_q[0] <= rd_addr_q[1];
        rs_data_q[0] <= fwd_pick(rs_addr_q[1], rs_data_q[1]);
        rt_data_q[0] <= fwd_pick(rt_addr_q[1], rt_data_q[1]);
      end
      if (accept) begin
        funct_q[wr_slot]   <= in_funct;
        shamt_q[wr_slot]   <= in_shamt;
        rs_addr_q[wr_slot] <= in_rs_addr;
        rt_addr_q[wr_slot] <= in_rt_addr;
        rd_addr_q[wr_slot] <= in_rd_addr;
        rs_data_q[wr_slot] <= fwd_pick(in_rs_addr, in_rs_data);
        rt_data_q[wr_slot] <= fwd_pick(in_rt_addr, in_rt_data);
      end
    end
  end

  alu_funct_decode u_decode (
    .funct     (funct_q[0]),
    .alu_op    (head_op),
    .shift_sel (head_shift)
  );

  assign ALUOp    = out_valid ? head_op : 4'h0;
  assign in1      = head_shift ? {{(DATA_WIDTH-5){1'b0}}, shamt_q[0]} : rs_data_q[0];
  assign in2      = rt_data_q[0];
  assign in3      = '0;
  assign in4      = '0;
  assign sel      = 1'b0;
  assign dst_addr = rd_addr_q[0];

endmodule
